// File: rtl/v16_pulse_gen_pkg.sv
// Shared types and default constants for the v16 synthetic detector-pulse source.
// Imported by the pulse generator top and its decay/saturation stage.
package v16_pulse_gen_pkg;

   localparam int SIZE_ADC_DATA = 12;
   localparam int TAU_SHIFT_DEF = 4;
   localparam int FRAC_DEF      = 8;
   localparam int MAX_LEN_DEF   = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DECAY = 2'd2,
      ST_GAP   = 2'd3
   } pg_state_t;

   // What the output register loads on this clk.
   typedef enum logic [1:0] {
      OUT_HOLD  = 2'd0,
      OUT_PEAK  = 2'd1,
      OUT_DECAY = 2'd2,
      OUT_BASE  = 2'd3
   } out_sel_t;

endpackage

// File: rtl/v16_decay_step.sv
// One exponential-decay step of the pulse accumulator plus the saturating
// baseline add, feeding the registered adc_data output.
module v16_decay_step
   import v16_pulse_gen_pkg::*;
#(
   parameter int DATA_W    = SIZE_ADC_DATA,
   parameter int TAU_SHIFT = TAU_SHIFT_DEF,
   parameter int FRAC      = FRAC_DEF,
   parameter int BASELINE  = 100
) (
   input  logic                     clk,
   input  logic                     reset,
   input  out_sel_t                 out_sel,
   input  logic [DATA_W+FRAC-1:0]   acc,
   input  logic [DATA_W-1:0]        amp,
   output logic [DATA_W+FRAC-1:0]   acc_n,
   output logic                     decay_done,
   output logic [DATA_W-1:0]        adc_data
);

   localparam int                ACC_W = DATA_W + FRAC;
   localparam logic [DATA_W-1:0] BASE  = DATA_W'(BASELINE);

   logic [DATA_W-1:0] acc_n_int;
   logic [DATA_W-1:0] peak_sat;
   logic [DATA_W-1:0] decay_sat;

   // Baseline add with one carry bit; any carry clamps to full scale.
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] x);
      logic [DATA_W:0] sum;
      sum = {1'b0, BASE} + {1'b0, x};
      return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
   endfunction

   always_comb begin
      acc_n      = acc - (acc >> TAU_SHIFT);
      acc_n_int  = acc_n[ACC_W-1:FRAC];
      decay_done = (acc_n_int == '0);
      peak_sat   = sat_add(amp);
      decay_sat  = sat_add(acc_n_int);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adc_data <= BASE;
      end else begin
         case (out_sel)
            OUT_PEAK:  adc_data <= peak_sat;
            OUT_DECAY: adc_data <= decay_sat;
            OUT_BASE:  adc_data <= BASE;
            default:   adc_data <= adc_data;
         endcase
      end
   end

endmodule

// File: rtl/v16_pulse_gen.sv
// Synthetic detector-pulse source: step to amplitude, exponential decay on a
// baseline, then a programmable quiet gap, all advanced by the ADC-rate strobe.
module v16_pulse_gen
   import v16_pulse_gen_pkg::*;
#(
   parameter int DATA_W    = SIZE_ADC_DATA,
   parameter int TAU_SHIFT = TAU_SHIFT_DEF,
   parameter int FRAC      = FRAC_DEF,
   parameter int BASELINE  = 100,
   parameter int MAX_LEN   = MAX_LEN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_en,
   input  logic              start,
   input  logic [DATA_W-1:0] amplitude,
   input  logic [15:0]       gap_len,
   output logic              busy,
   output logic              pulse_start,
   output logic [DATA_W-1:0] adc_data,
   output logic              data_valid,
   output pg_state_t         state_dbg
);

   // Request handshake: start is a level request taken only in IDLE (the
   // accept); busy rises the clk after accept and falls when the gap ends.
   // Requests while busy are dropped, never queued.

   localparam int ACC_W = DATA_W + FRAC;
   localparam int LEN_W = $clog2(MAX_LEN);

   pg_state_t         state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_n;
   logic [LEN_W-1:0]  len_cnt;
   logic [15:0]       gap_cnt, gap_len_q;
   logic [DATA_W-1:0] amp_q;
   logic              decay_done, decay_end, gap_end;
   logic              accept, load_peak, step_decay, gap_inc, busy_clr;
   out_sel_t          out_sel;

   assign decay_end = decay_done || (len_cnt == LEN_W'(MAX_LEN - 1));
   assign gap_end   = (gap_cnt == gap_len_q);
   assign state_dbg = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)                   state_d = ST_ARMED;
         ST_ARMED: if (sample_en)               state_d = ST_DECAY;
         ST_DECAY: if (sample_en && decay_end)  state_d = ST_GAP;
         ST_GAP:   if (sample_en && gap_end)    state_d = ST_IDLE;
         default:                               state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      accept     = 1'b0;
      load_peak  = 1'b0;
      step_decay = 1'b0;
      gap_inc    = 1'b0;
      busy_clr   = 1'b0;
      out_sel    = OUT_HOLD;
      case (state_q)
         ST_IDLE:  accept = start;
         ST_ARMED: begin
            load_peak = sample_en;
            if (sample_en) out_sel = OUT_PEAK;
         end
         ST_DECAY: begin
            step_decay = sample_en;
            if (sample_en) out_sel = decay_end ? OUT_BASE : OUT_DECAY;
         end
         ST_GAP: begin
            gap_inc  = sample_en && !gap_end;
            busy_clr = sample_en && gap_end;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q       <= '0;
         len_cnt     <= '0;
         gap_cnt     <= '0;
         amp_q       <= '0;
         gap_len_q   <= '0;
         busy        <= 1'b0;
         pulse_start <= 1'b0;
         data_valid  <= 1'b0;
      end else begin
         data_valid  <= sample_en;
         pulse_start <= load_peak;
         if (accept) begin
            amp_q     <= amplitude;
            gap_len_q <= gap_len;
            busy      <= 1'b1;
         end
         if (busy_clr) busy <= 1'b0;
         if (load_peak) begin
            acc_q   <= {amp_q, {FRAC{1'b0}}};
            len_cnt <= '0;
         end
         if (step_decay) begin
            acc_q   <= acc_n;
            len_cnt <= len_cnt + 1'b1;
            if (decay_end) gap_cnt <= '0;
         end
         if (gap_inc) gap_cnt <= gap_cnt + 16'd1;
      end
   end

   v16_decay_step #(
      .DATA_W    (DATA_W),
      .TAU_SHIFT (TAU_SHIFT),
      .FRAC      (FRAC),
      .BASELINE  (BASELINE)
   ) u_decay_step (
      .clk        (clk),
      .reset      (reset),
      .out_sel    (out_sel),
      .acc        (acc_q),
      .amp        (amp_q),
      .acc_n      (acc_n),
      .decay_done (decay_done),
      .adc_data   (adc_data)
   );

endmodule

// File: tb/tb_v16_pulse_gen.sv
// Directed bench for v16_pulse_gen: each launched pulse pushes its expected
// sample train into a queue that a negedge monitor pops on every data_valid.
module tb_v16_pulse_gen;
   import v16_pulse_gen_pkg::*;

   localparam int DATA_W  = 12;
   localparam int TAU     = 4;
   localparam int FRAC    = 8;
   localparam int BASE    = 100;
   localparam int MAX_LEN = 1024;
   localparam int W       = DATA_W + 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              sample_en;
   logic              start;
   logic [DATA_W-1:0] amplitude;
   logic [15:0]       gap_len;
   logic              busy;
   logic              pulse_start;
   logic [DATA_W-1:0] adc_data;
   logic              data_valid;
   pg_state_t         state_dbg;

   int checks = 0;
   int failures = 0;

   // Expected samples are {busy, pulse_start, adc_data}; len_q holds samples per pulse.
   logic [W-1:0]      exp_q[$];
   int                len_q[$];
   int                remaining = 0;
   logic [W-1:0]      exp_item;
   int                en_div = 1;
   int                en_phase = 0;
   logic              hold_chk = 1'b0;
   logic [DATA_W-1:0] prev_adc = '0;

   v16_pulse_gen dut (
      .clk         (clk),
      .reset       (reset),
      .sample_en   (sample_en),
      .start       (start),
      .amplitude   (amplitude),
      .gap_len     (gap_len),
      .busy        (busy),
      .pulse_start (pulse_start),
      .adc_data    (adc_data),
      .data_valid  (data_valid),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat_ref(input int x);
      return (x + BASE > (1 << DATA_W) - 1) ? (1 << DATA_W) - 1 : x + BASE;
   endfunction

   // Reference pulse: peak, decay samples, baseline return, gap_len+1 quiet samples.
   function automatic int push_pulse(input int amp, input int gap);
      int acc;
      int n;
      acc = amp << FRAC;
      n = 1;
      exp_q.push_back({1'b1, 1'b1, DATA_W'(sat_ref(amp))});
      for (int k = 0; k < MAX_LEN; k++) begin
         acc = acc - (acc >> TAU);
         n++;
         if ((acc >> FRAC) == 0 || k == MAX_LEN - 1) begin
            exp_q.push_back({1'b1, 1'b0, DATA_W'(BASE)});
            break;
         end
         exp_q.push_back({1'b1, 1'b0, DATA_W'(sat_ref(acc >> FRAC))});
      end
      for (int g = 0; g <= gap; g++) begin
         exp_q.push_back({(g != gap), 1'b0, DATA_W'(BASE)});
         n++;
      end
      len_q.push_back(n);
      return n;
   endfunction

   task automatic step();
      @(negedge clk);
      sample_en = (en_phase == 0);
      en_phase = (en_phase + 1) % en_div;
   endtask

   task automatic launch(input int amp, input int gap);
      void'(push_pulse(amp, gap));
      amplitude = DATA_W'(amp);
      gap_len = 16'(gap);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("accept_busy", 32'(busy), 1);
      chk("accept_no_flag", 32'(pulse_start), 0);
   endtask

   task automatic wait_pulse(input int max_cyc, input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!pulse_start && n < max_cyc);
      chk(tag, 32'(pulse_start), 1);
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n = 0;
      while (busy && n < max_cyc) begin
         step();
         n++;
      end
      chk(tag, 32'(busy), 0);
   endtask

   task automatic drain(input string tag);
      step();
      chk(tag, 32'(exp_q.size()), 0);
   endtask

   // Monitor: a pulse_start opens a pulse, then each valid sample is compared.
   always @(negedge clk) begin
      if (!reset && data_valid) begin
         if (remaining == 0 && pulse_start) begin
            chk("pulse_expected", 32'(len_q.size() != 0), 1);
            if (len_q.size() != 0) remaining = len_q.pop_front();
         end
         if (remaining > 0) begin
            exp_item = exp_q.pop_front();
            chk("sample", 32'({busy, pulse_start, adc_data}), 32'(exp_item));
            remaining--;
         end
      end
      if (hold_chk && !data_valid) chk("hold_between_strobes", 32'(adc_data), 32'(prev_adc));
      prev_adc = adc_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int l3;
      int cyc;
      int n_ps;
      int busy_low;
      int t_ps[2];

      reset = 1'b1;
      sample_en = 1'b0;
      start = 1'b0;
      amplitude = '0;
      gap_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_adc", 32'(adc_data), BASE);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flag", 32'(pulse_start), 0);
      chk("rst_valid", 32'(data_valid), 0);
      chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      reset = 1'b0;
      step();
      step();
      chk("idle_valid", 32'(data_valid), 1);
      chk("idle_adc", 32'(adc_data), BASE);

      // Basic pulse with explicit first samples.
      launch(1600, 4);
      step();
      chk("t1_flag", 32'(pulse_start), 1);
      chk("t1_peak", 32'(adc_data), 1700);
      step();
      chk("t1_s1", 32'(adc_data), 1600);
      chk("t1_flag_once", 32'(pulse_start), 0);
      step();
      chk("t1_s2", 32'(adc_data), 1506);
      wait_idle(400, "t1_idle");
      drain("t1_drain");
      chk("t1_end_adc", 32'(adc_data), BASE);

      // Full-scale amplitude saturates without wrapping.
      launch(4095, 2);
      step();
      chk("t2_peak", 32'(adc_data), 4095);
      step();
      chk("t2_s1", 32'(adc_data), 3939);
      wait_idle(400, "t2_idle");
      drain("t2_drain");

      // Start held high: back-to-back pulses with a single idle clk.
      l3 = push_pulse(50, 0);
      void'(push_pulse(50, 0));
      amplitude = DATA_W'(50);
      gap_len = 16'd0;
      start = 1'b1;
      cyc = 0;
      n_ps = 0;
      busy_low = 0;
      while (n_ps < 2 && cyc < 1000) begin
         step();
         cyc++;
         if (n_ps == 1 && !busy) busy_low++;
         if (pulse_start) begin
            t_ps[n_ps] = cyc;
            n_ps++;
         end
      end
      start = 1'b0;
      chk("t3_two_pulses", 32'(n_ps), 2);
      chk("t3_spacing", 32'(t_ps[1] - t_ps[0]), 32'(l3 + 1));
      chk("t3_busy_low", 32'(busy_low), 1);
      wait_idle(400, "t3_idle");
      drain("t3_drain");

      // Start and amplitude changes during DECAY and GAP are ignored.
      launch(800, 6);
      wait_pulse(10, "t4_pulse");
      repeat (5) step();
      amplitude = DATA_W'(3000);
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (state_dbg != ST_GAP && cyc < 400) begin
         step();
         cyc++;
      end
      chk("t4_in_gap", 32'(state_dbg), 32'(ST_GAP));
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle(400, "t4_idle");
      repeat (20) step();
      chk("t4_no_restart", 32'(busy), 0);
      chk("t4_no_pending", 32'(len_q.size()), 0);
      drain("t4_drain");

      // Asynchronous reset in the middle of the decay.
      launch(1600, 4);
      wait_pulse(10, "t5_pulse");
      repeat (10) step();
      reset = 1'b1;
      #1;
      chk("t5_rst_adc", 32'(adc_data), BASE);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_flag", 32'(pulse_start), 0);
      exp_q.delete();
      len_q.delete();
      remaining = 0;
      step();
      step();
      reset = 1'b0;
      step();
      launch(200, 0);
      step();
      chk("t5_new_peak", 32'(adc_data), 300);
      wait_idle(400, "t5_idle");
      drain("t5_drain");

      // Strobe 1-in-4: same samples, output frozen between strobes.
      en_div = 4;
      en_phase = 0;
      hold_chk = 1'b1;
      step();
      launch(1600, 4);
      wait_pulse(20, "t6_pulse");
      chk("t6_peak", 32'(adc_data), 1700);
      wait_idle(2000, "t6_idle");
      repeat (4) step();
      drain("t6_drain");
      hold_chk = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
